// File: rtl/lsu_align.sv
// Load/store alignment unit: splits byte/half/word requests at any byte address into
// one or two word-aligned dataMem accesses and assembles sign/zero-extended load results.
module lsu_align #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_uns_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          resp_valid_o,
  output logic [31:0]   resp_rdata_o,
  output logic          resp_err_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, next_state;

  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   lo_q;
  logic [31:0]   hi_q;

  logic [1:0]    off;
  logic [3:0]    base_mask;
  logic [7:0]    mask8;
  logic [63:0]   wd64;
  logic          split;
  logic [AW-1:0] word_addr;
  logic          accept;
  logic [63:0]   merged;
  logic [31:0]   raw;

  assign accept    = req_valid_i && (state == IDLE);
  assign off       = addr_q[1:0];
  assign word_addr = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    case (size_q)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  end

  assign mask8 = {4'b0000, base_mask} << off;
  assign wd64  = {32'b0, wdata_q} << {off, 3'b000};
  assign split = |mask8[7:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = 4'b0000;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) next_state = (req_size_i == 2'b11) ? RESP : ACC1;
      end
      ACC1: begin
        mem_we_o    = we_q;
        mem_addr_o  = word_addr;
        mem_wdata_o = wd64[31:0];
        mem_be_o    = we_q ? mask8[3:0] : 4'b0000;
        next_state  = split ? ACC2 : RESP;
      end
      ACC2: begin
        mem_we_o    = we_q;
        mem_addr_o  = word_addr + AW'(4);
        mem_wdata_o = wd64[63:32];
        mem_be_o    = we_q ? mask8[7:4] : 4'b0000;
        next_state  = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are held for the whole operation; hi stays 0 unless a second access reads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        uns_q   <= req_uns_i;
        err_q   <= (req_size_i == 2'b11);
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (state == ACC1 && !we_q) lo_q <= mem_rdata_i;
      if (state == ACC2 && !we_q) hi_q <= mem_rdata_i;
    end
  end

  assign merged = {hi_q, lo_q} >> {off, 3'b000};
  assign raw    = merged[31:0];

  always_comb begin
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    if (state == RESP) begin
      resp_err_o = err_q;
      if (!we_q && !err_q) begin
        case (size_q)
          2'b00:   resp_rdata_o = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
          2'b01:   resp_rdata_o = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
          default: resp_rdata_o = raw;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a small byte-enabled word memory standing in for dataMem.
module tb_lsu_align;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_uns_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  int tests_run;
  int tests_failed;

  logic [31:0] mem [0:255];
  logic        mem_clear;

  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  logic [31:0] acc_addr [1:2];
  logic [3:0]  acc_be [1:2];
  logic        saw_we;

  lsu_align #(.AW(32), .DW(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we_i),
    .req_size_i(req_size_i),
    .req_uns_i(req_uns_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o[9:2]];

  // Byte-enabled write memory; address bits above 9 are ignored so 0xFFFFFFFC lands in the last word.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  // Issues one request and records every access cycle until the response pulse.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int waited;
    bit got;
    waited = 0;
    @(negedge clk);
    while (!req_ready_o && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_size_i  = size;
    req_uns_i   = uns;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    last_rdata  = 32'hxxxx_xxxx;
    last_err    = 1'bx;
    last_lat    = 0;
    saw_we      = 1'b0;
    acc_addr[1] = '0; acc_addr[2] = '0;
    acc_be[1]   = '0; acc_be[2]   = '0;
    got = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (mem_we_o) saw_we = 1'b1;
      if (resp_valid_o) begin
        last_rdata = resp_rdata_o;
        last_err   = resp_err_o;
        last_lat   = c;
        got = 1;
      end else if (c <= 2) begin
        acc_addr[c] = mem_addr_o;
        acc_be[c]   = mem_be_o;
      end
    end
    if (!got) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    mem_clear    = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_size_i   = 2'b00;
    req_uns_i    = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    repeat (3) @(negedge clk);
    mem_clear = 1'b0;

    checkOutput("reset_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("reset_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("reset_mem_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("reset_mem_be", {28'b0, mem_be_o}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr_o, 32'd0);
    checkOutput("reset_rdata", resp_rdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, req_ready_o}, 32'd1);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checkOutput("sw_addr", acc_addr[1], 32'h10);
    checkOutput("sw_be", {28'b0, acc_be[1]}, 32'hF);
    checkOutput("sw_lat", last_lat, 2);
    checkOutput("sw_rdata_zero", last_rdata, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("lw_rdata", last_rdata, 32'hDEADBEEF);
    checkOutput("lw_lat", last_lat, 2);
    checkOutput("lw_be_zero", {28'b0, acc_be[1]}, 32'h0);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h80);
    checkOutput("sb_be", {28'b0, acc_be[1]}, 32'h8);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checkOutput("lb_signed", last_rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checkOutput("lbu", last_rdata, 32'h00000080);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("lw_after_sb", last_rdata, 32'h80ADBEEF);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'h17, 32'hA55A);
    checkOutput("sh_split_addr1", acc_addr[1], 32'h14);
    checkOutput("sh_split_be1", {28'b0, acc_be[1]}, 32'h8);
    checkOutput("sh_split_addr2", acc_addr[2], 32'h18);
    checkOutput("sh_split_be2", {28'b0, acc_be[2]}, 32'h1);
    checkOutput("sh_split_lat", last_lat, 3);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h17, 32'h0);
    checkOutput("lh_split_signed", last_rdata, 32'hFFFFA55A);
    checkOutput("lh_split_lat", last_lat, 3);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h17, 32'h0);
    checkOutput("lhu_split", last_rdata, 32'h0000A55A);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h1E, 32'h11223344);
    checkOutput("sw_split_addr1", acc_addr[1], 32'h1C);
    checkOutput("sw_split_be1", {28'b0, acc_be[1]}, 32'hC);
    checkOutput("sw_split_addr2", acc_addr[2], 32'h20);
    checkOutput("sw_split_be2", {28'b0, acc_be[2]}, 32'h3);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h1E, 32'h0);
    checkOutput("lw_split", last_rdata, 32'h11223344);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
    checkOutput("lw_1c", last_rdata, 32'h33440000);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checkOutput("lw_20", last_rdata, 32'h00001122);

    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
    checkOutput("err_flag", {31'b0, last_err}, 32'd1);
    checkOutput("err_lat", last_lat, 1);
    checkOutput("err_no_we", {31'b0, saw_we}, 32'd0);
    checkOutput("err_rdata", last_rdata, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("mem_after_err", last_rdata, 32'h80ADBEEF);
    checkOutput("ok_err_clear", {31'b0, last_err}, 32'd0);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF);
    checkOutput("wrap_addr1", acc_addr[1], 32'hFFFFFFFC);
    checkOutput("wrap_addr2", acc_addr[2], 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0);
    checkOutput("wrap_lhu", last_rdata, 32'h0000BEEF);

    // Clear both words, then abort a split store during its second access.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h18, 32'h0);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 2'b01;
    req_uns_i   = 1'b0;
    req_addr_i  = 32'h17;
    req_wdata_i = 32'hA55A;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_rst_acc2_be", {28'b0, mem_be_o}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("rst_mid_be", {28'b0, mem_be_o}, 32'd0);
    checkOutput("rst_mid_addr", mem_addr_o, 32'd0);
    checkOutput("rst_mid_resp", {31'b0, resp_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ready", {31'b0, req_ready_o}, 32'd1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    checkOutput("rst_mid_w14", last_rdata, 32'h5A000000);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    checkOutput("rst_mid_w18", last_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
